button_event_serializer: RTL and testbench
==========================================

BUTTON_EVENT_SERIALIZER -- requirements
Module: button_event_serializer

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, default 4, number of buttons and the FIFO data width.
- IDX_W, default 2, width of the button index; SHALL equal clog2(WIDTH), minimum 1.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- fifo_dout  in  WIDTH  event word from the upstream button FIFO; bit i set = button i pressed.
- fifo_empty  in  1  upstream FIFO empty.
- fifo_rd_en  out  1  pop request to the upstream FIFO.
- evt_valid  out  1  a single-button event is presented.
- evt_ready  in  1  consumer accepts the event.
- evt_idx  out  IDX_W  index of the presented button.
- evt_multi  out  1  the presented event came from a word with more than one bit set.
- cnt_sel  in  IDX_W  counter select (see Configuration).
- cnt_out  out  8  selected event counter value.

Function
REQ-003 The upstream FIFO is read with 1-cycle latency: fifo_dout SHALL be sampled in the cycle after the cycle in which fifo_rd_en=1.
REQ-004 The FSM SHALL have three states: IDLE, FETCH, SERVE.
REQ-005 fifo_rd_en SHALL be combinational and SHALL equal (state==IDLE) && !fifo_empty; it SHALL be high for exactly one cycle per pop.
REQ-006 Transitions SHALL be:
- IDLE to FETCH when fifo_rd_en=1.
- FETCH: capture fifo_dout into pending[WIDTH-1:0]; go to SERVE if the captured value is nonzero, else back to IDLE with the word discarded.
REQ-007 In SERVE, evt_valid SHALL be 1, evt_idx SHALL be the lowest set bit of pending, and evt_multi SHALL be 1 if the captured word had popcount >= 2.
- evt_multi SHALL hold its value for every event serialized from that word.
REQ-008 On evt_valid && evt_ready, the presented bit SHALL be cleared from pending.
- If pending becomes zero, the FSM SHALL return to IDLE; otherwise it SHALL stay in SERVE and present the next lowest bit in the following cycle.
REQ-009 While evt_valid=1 and evt_ready=0, evt_idx and evt_multi SHALL remain stable; no FIFO read SHALL occur.
REQ-010 Latency SHALL be 2 cycles: fifo_empty falls with the FSM in IDLE at edge N; evt_valid rises after edge N+2.
REQ-011 A word with k set bits SHALL produce exactly k handshakes, in ascending index order, with no bubble between them when evt_ready is held at 1.
REQ-012 There SHALL be exactly one idle cycle (IDLE) between the last handshake of one word and the next fifo_rd_en.
REQ-013 evt_valid, evt_idx and evt_multi SHALL be registered outputs; fifo_rd_en is the only combinational output.

Reset
REQ-014 While rst=0, and asynchronously on its assertion:
- state SHALL be IDLE; pending, evt_idx, evt_multi and all counters SHALL be 0; evt_valid SHALL be 0.
- fifo_rd_en SHALL be 0 while rst=0.
REQ-015 Reset asserted in FETCH or SERVE SHALL discard the pending word; no partial event SHALL be presented after release.
REQ-016 The first fifo_rd_en after release SHALL occur no earlier than the first rising edge with rst=1.

Configuration
REQ-017 Macro BTN_SER_EVENT_CNT_EN defined: the block SHALL keep one 8-bit counter per button.
- A counter SHALL increment on each handshake for its index and saturate at 255 (no wrap).
- cnt_out SHALL be the combinational readout of counter[cnt_sel]; a cnt_sel >= WIDTH SHALL read 0.
REQ-018 Macro BTN_SER_EVENT_CNT_EN undefined: no counters SHALL be synthesized, cnt_out SHALL be constant 0 and cnt_sel SHALL be ignored; all other behaviour SHALL be identical.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single word: WIDTH=4, FIFO word 4'b0100, evt_ready=1 -> one handshake with evt_idx=2, evt_multi=0, exactly 2 cycles after fifo_empty fell.
- Multi-bit word: FIFO word 4'b1011, evt_ready=1 -> handshakes evt_idx=0,1,3 on consecutive cycles, evt_multi=1 on all three, then IDLE.
- Backpressure: word 4'b0110 with evt_ready=0 for 5 cycles -> evt_idx=1 stable and fifo_rd_en=0 throughout; then evt_ready=1 -> idx 1 then idx 2.
- Reset mid-SERVE: word 4'b1111, assert rst after the first handshake -> evt_valid=0 immediately; after release no event until the next FIFO word.
- Counter saturation (macro defined): 300 events on button 3 -> cnt_out=255 with cnt_sel=3, and cnt_out=0 with cnt_sel=0. Macro undefined -> cnt_out=0 always.
- Zero word: FIFO word 4'b0000 -> popped, no evt_valid, FSM back in IDLE after FETCH.

Source files
------------

// File: rtl/button_event_serializer.sv
// button_event_serializer
//
// Pops multi-hot button words from an upstream FIFO (1-cycle read latency)
// and serializes each word into one single-button event per set bit, lowest
// index first, using a valid/ready handshake towards the consumer.
//
// Optional feature: define BTN_SER_EVENT_CNT_EN to keep a saturating 8-bit
// event counter per button, readable through cnt_sel/cnt_out. Without the
// macro no counters exist, cnt_out is tied to 0 and cnt_sel is ignored.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      asynchronous, active-low reset
//   fifo_dout   in   WIDTH  upstream event word, bit i = button i pressed
//   fifo_empty  in   1      upstream FIFO empty
//   fifo_rd_en  out  1      pop request (combinational)
//   evt_valid   out  1      single-button event presented (registered)
//   evt_ready   in   1      consumer accepts the event
//   evt_idx     out  IDX_W  index of the presented button (registered)
//   evt_multi   out  1      event came from a word with >= 2 bits set
//   cnt_sel     in   IDX_W  counter select
//   cnt_out     out  8      selected counter value
module button_event_serializer #(
    parameter int WIDTH = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_multi,
    input  logic [IDX_W-1:0] cnt_sel,
    output logic [7:0]       cnt_out
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SERVE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_clr;
    logic             handshake;

    function automatic logic [IDX_W-1:0] lowest_bit(input logic [WIDTH-1:0] w);
        lowest_bit = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w[i]) begin
                lowest_bit = IDX_W'(i);
            end
        end
    endfunction

    assign handshake   = evt_valid && evt_ready;
    // pending with the currently presented bit removed
    assign pending_clr = pending & ~(WIDTH'(1) << evt_idx);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Gating with rst keeps the pop request low while reset is held,
    // even though the state register already reads IDLE.
    always_comb begin
        state_next = state;
        fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (rst && !fifo_empty) begin
                    fifo_rd_en = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = (fifo_dout != '0) ? SERVE : IDLE;
            end
            SERVE: begin
                if (handshake && (pending_clr == '0)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Event registers: loaded when the popped word arrives, advanced to the
    // next lowest bit on every accepted event. evt_multi is only written on
    // capture so it stays constant for all events of one word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending   <= '0;
            evt_valid <= 1'b0;
            evt_idx   <= '0;
            evt_multi <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    pending <= fifo_dout;
                    if (fifo_dout != '0) begin
                        evt_valid <= 1'b1;
                        evt_idx   <= lowest_bit(fifo_dout);
                        evt_multi <= |(fifo_dout & (fifo_dout - WIDTH'(1)));
                    end
                end
                SERVE: begin
                    if (handshake) begin
                        pending <= pending_clr;
                        evt_idx <= lowest_bit(pending_clr);
                        if (pending_clr == '0) begin
                            evt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BTN_SER_EVENT_CNT_EN
    logic [7:0] counters [WIDTH];

    // Per-button counters, saturating at 255
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                counters[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (handshake && (32'(evt_idx) == i) && (counters[i] != 8'hFF)) begin
                    counters[i] <= counters[i] + 8'd1;
                end
            end
        end
    end

    // A select value with no matching button reads as 0
    always_comb begin
        cnt_out = 8'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (32'(cnt_sel) == i) begin
                cnt_out = counters[i];
            end
        end
    end
`else
    logic unused_cnt_sel;

    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_out        = 8'd0;
`endif

endmodule

// File: tb/tb_button_event_serializer.sv
// tb_button_event_serializer
//
// Directed bench for button_event_serializer (WIDTH=4). Words pushed into
// the FIFO model also push their expected events into a scoreboard queue; a
// monitor pops and compares on every accepted event. Cycle-exact behaviour
// (latency, backpressure, reset) is checked directly by the stimulus.
// Counter expectations follow BTN_SER_EVENT_CNT_EN.
module tb_button_event_serializer;

    localparam int WIDTH = 4;
    localparam int IDX_W = 2;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             multi;
    } exp_t;

    logic             clk        = 1'b0;
    logic             rst        = 1'b0;
    logic [WIDTH-1:0] fifo_dout  = '0;
    logic             fifo_empty = 1'b1;
    logic             fifo_rd_en;
    logic             evt_valid;
    logic             evt_ready  = 1'b1;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_multi;
    logic [IDX_W-1:0] cnt_sel    = '0;
    logic [7:0]       cnt_out;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] fifo_q[$];
    int               model_cnt [WIDTH];
    int               total = 0;
    int               bad   = 0;

    button_event_serializer #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_dout (fifo_dout),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_idx   (evt_idx),
        .evt_multi (evt_multi),
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: data appears the cycle after a pop, and the empty
    // flag reflects the queue as of the last clock edge.
    always @(posedge clk) begin
        if (fifo_rd_en && (fifo_q.size() > 0)) begin
            fifo_dout <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue a FIFO word and its expected events, lowest index first
    task automatic apply_stimulus(input logic [WIDTH-1:0] w);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) ones++;
        end
        fifo_q.push_back(w);
        for (int i = 0; i < WIDTH; i++) begin
            if (w[i]) begin
                e.idx   = IDX_W'(i);
                e.multi = (ones >= 2);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && evt_valid && evt_ready) begin
                check_output("sb_event_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_output("sb_evt_idx", 32'(evt_idx), 32'(e.idx));
                    check_output("sb_evt_multi", 32'(evt_multi), 32'(e.multi));
                    if (model_cnt[e.idx] < 255) model_cnt[e.idx]++;
                end
            end
        end
    endtask

    task automatic wait_valid();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (evt_valid) ok = 1'b1;
        end
        check_output("wait_valid", 32'(ok), 1);
    endtask

    task automatic drain(input int max_cycles);
        logic done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            tick();
            if ((exp_q.size() == 0) && (fifo_q.size() == 0) && !evt_valid && fifo_empty) begin
                done = 1'b1;
            end
        end
        check_output("drain", 32'(done), 1);
        tick();
        tick();
    endtask

    task automatic check_cnt(input logic [IDX_W-1:0] sel);
        int e;
        cnt_sel = sel;
        #1;
`ifdef BTN_SER_EVENT_CNT_EN
        e = model_cnt[sel];
`else
        e = 0;
`endif
        check_output($sformatf("cnt_out_sel%0d", sel), 32'(cnt_out), 32'(e));
    endtask

    initial begin
        for (int i = 0; i < WIDTH; i++) model_cnt[i] = 0;
        fork
            monitor();
        join_none

        // Reset: a word waits in the FIFO but must not be popped
        repeat (2) tick();
        apply_stimulus(4'b0010);
        repeat (3) tick();
        check_output("rst_rd_en", 32'(fifo_rd_en), 0);
        check_output("rst_valid", 32'(evt_valid), 0);
        check_output("rst_idx", 32'(evt_idx), 0);
        check_output("rst_multi", 32'(evt_multi), 0);
        check_cnt(2'd0);
        rst = 1'b1;
        drain(50);

        // Single word, 2-cycle latency from fifo_empty falling
        apply_stimulus(4'b0100);
        tick();
        check_output("single_rd_en", 32'(fifo_rd_en), 1);
        tick();
        check_output("single_valid_n1", 32'(evt_valid), 0);
        tick();
        check_output("single_valid_n2", 32'(evt_valid), 1);
        check_output("single_idx", 32'(evt_idx), 2);
        check_output("single_multi", 32'(evt_multi), 0);
        tick();
        check_output("single_done", 32'(evt_valid), 0);
        drain(50);

        // Multi-bit word back to back, then one idle cycle before next pop
        apply_stimulus(4'b1011);
        apply_stimulus(4'b0001);
        wait_valid();
        check_output("multi_idx0", 32'(evt_idx), 0);
        check_output("multi_m0", 32'(evt_multi), 1);
        tick();
        check_output("multi_v1", 32'(evt_valid), 1);
        check_output("multi_idx1", 32'(evt_idx), 1);
        tick();
        check_output("multi_v3", 32'(evt_valid), 1);
        check_output("multi_idx3", 32'(evt_idx), 3);
        check_output("multi_m3", 32'(evt_multi), 1);
        tick();
        check_output("multi_end_valid", 32'(evt_valid), 0);
        check_output("multi_idle_rd_en", 32'(fifo_rd_en), 1);
        tick();
        check_output("multi_fetch_rd_en", 32'(fifo_rd_en), 0);
        tick();
        check_output("next_valid", 32'(evt_valid), 1);
        check_output("next_idx", 32'(evt_idx), 0);
        check_output("next_multi", 32'(evt_multi), 0);
        drain(50);

        // Backpressure with another word waiting in the FIFO
        evt_ready = 1'b0;
        apply_stimulus(4'b0110);
        apply_stimulus(4'b1000);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check_output("bp_valid", 32'(evt_valid), 1);
            check_output("bp_idx", 32'(evt_idx), 1);
            check_output("bp_multi", 32'(evt_multi), 1);
            check_output("bp_rd_en", 32'(fifo_rd_en), 0);
            tick();
        end
        evt_ready = 1'b1;
        tick();
        check_output("bp_next_idx", 32'(evt_idx), 2);
        check_output("bp_next_valid", 32'(evt_valid), 1);
        drain(50);

        // Reset after the first handshake of 4'b1111
        apply_stimulus(4'b1111);
        wait_valid();
        tick();
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < WIDTH; i++) model_cnt[i] = 0;
        #1;
        check_output("midrst_valid", 32'(evt_valid), 0);
        check_output("midrst_idx", 32'(evt_idx), 0);
        check_output("midrst_rd_en", 32'(fifo_rd_en), 0);
        check_cnt(2'd3);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output("postrst_quiet", 32'(evt_valid), 0);
        end
        apply_stimulus(4'b0001);
        drain(50);

        // Zero word is popped and dropped; FSM returns to IDLE after FETCH
        apply_stimulus(4'b0000);
        apply_stimulus(4'b0100);
        tick();
        check_output("zero_rd_en", 32'(fifo_rd_en), 1);
        tick();
        check_output("zero_fetch_valid", 32'(evt_valid), 0);
        tick();
        check_output("zero_back_valid", 32'(evt_valid), 0);
        check_output("zero_back_rd_en", 32'(fifo_rd_en), 1);
        drain(50);

        // Counter saturation on button 3
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(4'b1000);
        end
        drain(3000);
        check_cnt(2'd3);
        check_cnt(2'd0);
        check_cnt(2'd2);
        check_cnt(2'd1);

        check_output("sb_leftover", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
